// File: rtl/pc_sequencer.sv
// Program counter with next-PC selection: boot select, seq/branch/jump, single-level IRQ with EPC.
// Optional PC_IRQ_COUNT_EN adds a saturating 16-bit interrupt-entry counter output irq_count.
module pc_sequencer #(
  parameter int          WIDTH       = 32,
  parameter int          STEP        = 1,
  parameter int          PROG_SEL_W  = 1,
  parameter int          BOOT_BASE   = 0,
  parameter int          BOOT_STRIDE = 11,
  parameter logic [31:0] IRQ_VECTOR  = 32'h80
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PROG_SEL_W-1:0] prog_sel,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [WIDTH-1:0]      branch_target,
  input  logic                  jump,
  input  logic [WIDTH-1:0]      jump_target,
  input  logic                  interrupt,
  input  logic                  eret,
`ifdef PC_IRQ_COUNT_EN
  output logic [15:0]           irq_count,
`endif
  output logic [WIDTH-1:0]      programCounter,
  output logic [WIDTH-1:0]      epc,
  output logic                  in_handler,
  output logic                  irq_ack
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HANDLER} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             ack_q, ack_d;

  logic [WIDTH-1:0] seq, nxt, boot_pc, irq_vec;

  assign seq     = pc_q + WIDTH'(STEP);
  assign nxt     = jump ? jump_target : (branch_taken ? branch_target : seq);
  assign boot_pc = WIDTH'(BOOT_BASE) + WIDTH'(prog_sel) * WIDTH'(BOOT_STRIDE);
  assign irq_vec = WIDTH'(IRQ_VECTOR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      epc_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:    state_d = ST_RUN;
      ST_RUN:     if (!stall && interrupt) state_d = ST_HANDLER;
      ST_HANDLER: if (!stall && eret)      state_d = ST_RUN;
      default:    state_d = ST_BOOT;
    endcase
  end

  // Interrupt wins over jump/branch in RUN, but their target is what gets saved as EPC.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    ack_d = 1'b0;
    unique case (state_q)
      ST_BOOT: pc_d = boot_pc;
      ST_RUN: begin
        if (!stall) begin
          if (interrupt) begin
            epc_d = nxt;
            pc_d  = irq_vec;
            ack_d = 1'b1;
          end else begin
            pc_d = nxt;
          end
        end
      end
      ST_HANDLER: begin
        if (!stall) pc_d = eret ? epc_q : nxt;
      end
      default: pc_d = '0;
    endcase
  end

`ifdef PC_IRQ_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ack_d && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign irq_count = cnt_q;
`endif

  assign programCounter = pc_q;
  assign epc            = epc_q;
  assign in_handler     = (state_q == ST_HANDLER);
  assign irq_ack        = ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance plus an 8-bit STEP=4 instance for wrap.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        prog_sel;
  logic        stall, branch_taken, jump, interrupt, eret;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, epc;
  logic        in_handler, irq_ack;
`ifdef PC_IRQ_COUNT_EN
  logic [15:0] irq_count;
`endif

  logic        reset_b, jump_b;
  logic [7:0]  jump_target_b, pc_b, epc_b;
  logic        in_handler_b, irq_ack_b;

  int tests = 0;
  int errs  = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .prog_sel(prog_sel), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .interrupt(interrupt), .eret(eret),
`ifdef PC_IRQ_COUNT_EN
    .irq_count(irq_count),
`endif
    .programCounter(pc), .epc(epc), .in_handler(in_handler), .irq_ack(irq_ack)
  );

  pc_sequencer #(.WIDTH(8), .STEP(4)) dut_b (
    .clock(clock), .reset(reset_b), .prog_sel(1'b0), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(8'h00),
    .jump(jump_b), .jump_target(jump_target_b),
    .interrupt(1'b0), .eret(1'b0),
`ifdef PC_IRQ_COUNT_EN
    .irq_count(),
`endif
    .programCounter(pc_b), .epc(epc_b), .in_handler(in_handler_b), .irq_ack(irq_ack_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] p, input logic [31:0] e,
                           input logic h, input logic a);
    chk({tag, ".pc"}, pc, p);
    chk({tag, ".epc"}, epc, e);
    chk({tag, ".in_handler"}, {31'd0, in_handler}, {31'd0, h});
    chk({tag, ".irq_ack"}, {31'd0, irq_ack}, {31'd0, a});
  endtask

  initial begin
    reset = 1'b0; reset_b = 1'b0; prog_sel = 1'b1;
    stall = 0; branch_taken = 0; jump = 0; interrupt = 0; eret = 0;
    branch_target = '0; jump_target = '0; jump_b = 0; jump_target_b = '0;
    #12;
    chk_state("reset", 0, 0, 0, 0);
    reset = 1'b1; reset_b = 1'b1;

    // Boot program 1, then 8-bit wrap on the second instance in parallel
    step(); chk("boot1", pc, 11); chk("b_boot", {24'd0, pc_b}, 0);
    jump_b = 1; jump_target_b = 8'hFC;
    step(); chk("boot1+1", pc, 12); chk("b_jump", {24'd0, pc_b}, 32'hFC);
    jump_b = 0;
    step(); chk("boot1+2", pc, 13); chk("b_wrap", {24'd0, pc_b}, 32'h00);
    chk("b_in_handler", {31'd0, in_handler_b}, 0);

    // Boot program 0
    @(posedge clock); #2; reset = 1'b0; prog_sel = 1'b0; #1;
    chk("reboot_pc", pc, 0);
    reset = 1'b1;
    step(); chk("boot0", pc, 0);
    step(); chk("boot0+1", pc, 1);
    step(); chk("boot0+2", pc, 2);
    step(); step(); step(); chk("run5", pc, 5);

    // Stall three cycles, boot select ignored after BOOT
    stall = 1; prog_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall", pc, 5);
    end
    stall = 0;
    step(); chk("unstall", pc, 6);

    // Priority: jump over branch
    jump = 1; jump_target = 20;
    step(); chk("jump20", pc, 20);
    branch_taken = 1; branch_target = 50; jump_target = 100;
    step(); chk("jump_beats_branch", pc, 100);
    jump = 0;
    step(); chk("branch50", pc, 50);
    branch_taken = 0;

    // Interrupt entry at PC=7, held level is masked in handler
    jump = 1; jump_target = 7;
    step(); chk("jump7", pc, 7);
    jump = 0; interrupt = 1;
    step(); chk_state("irq_entry", 32'h80, 8, 1, 1);
    step(); chk_state("irq_masked", 32'h81, 8, 1, 0);
    interrupt = 0;
    step(); step(); chk("handler83", pc, 32'h83);
    eret = 1;
    step(); chk_state("eret", 8, 8, 0, 0);
    eret = 0;

    // Interrupt pending under stall is taken once stall drops
    stall = 1; interrupt = 1;
    step(); chk_state("irq_stalled", 8, 8, 0, 0);
    stall = 0;
    step(); chk_state("irq_after_stall", 32'h80, 9, 1, 1);

    // eret together with interrupt: return first, then back-to-back entry
    eret = 1;
    step(); chk_state("eret_with_irq", 9, 9, 0, 0);
    eret = 0;
    step(); chk_state("back_to_back", 32'h80, 10, 1, 1);
`ifdef PC_IRQ_COUNT_EN
    chk("irq_count3", {16'd0, irq_count}, 3);
`endif

    // Asynchronous reset mid-handler, between edges
    interrupt = 0;
    #2; reset = 1'b0; #1;
    chk_state("async_reset", 0, 0, 0, 0);
`ifdef PC_IRQ_COUNT_EN
    chk("irq_count_clr", {16'd0, irq_count}, 0);
`endif
    step(); chk("reset_held", pc, 0);
    reset = 1'b1; prog_sel = 1'b0;
    step(); chk("reboot", pc, 0);

    // eret in RUN has no effect
    eret = 1;
    step(); chk_state("eret_in_run", 1, 0, 0, 0);
    eret = 0;

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
